rom_streamer: RTL and testbench
===============================

// Module: rom_streamer
// PURPOSE
//  Read-side sequencer for the synchronous ROM: on a start command, walks ROM addresses
//  base..base+len-1 and emits each word on a valid/ready stream with last-beat flag.
//  Absorbs the ROM's fixed 1-cycle read latency and downstream backpressure with a
//  2-entry buffer; sustains 1 word/cycle when m_ready_i is held high.
// PARAMETERS
//  DATA_WIDTH  8  ROM word width; must match the ROM instance.
//  ADDR_WIDTH  8  ROM address width; ROM depth = 2**ADDR_WIDTH.
// PORTS
//  clk_i       in   1             Single clock; all logic on rising edge.
//  rst_n_i     in   1             Reset: synchronous, active-low.
//  start_i     in   1             Command strobe; accepted only when busy_o==0.
//  base_i      in   ADDR_WIDTH    First ROM address; sampled with start_i.
//  len_i       in   ADDR_WIDTH+1  Word count, 0..2**ADDR_WIDTH; sampled with start_i.
//  busy_o      out  1             High from accepted start until last beat handshaken.
//  done_o      out  1             1-cycle pulse in the cycle after the last handshake.
//  rom_addr_o  out  ADDR_WIDTH    To ROM addr_i; driven from the address register.
//  rom_data_i  in   DATA_WIDTH    From ROM data_o; valid 1 cycle after rom_addr_o.
//  m_data_o    out  DATA_WIDTH    Stream data; registered (buffer head).
//  m_valid_o   out  1             Stream valid; registered.
//  m_last_o    out  1             High with the final word of the command.
//  m_ready_i   in   1             Downstream ready; handshake = m_valid_o & m_ready_i.
// BEHAVIOUR
//  - Reset (rst_n_i==0 at edge): state IDLE, busy_o=0, done_o=0, m_valid_o=0,
//    m_last_o=0, m_data_o=0, rom_addr_o=0, buffer empty, pending=0. Applies mid-command:
//    the command is dropped, no done_o pulse, in-flight ROM read discarded.
//  - FSM: IDLE -> RUN on start_i with len_i!=0; RUN -> DRAIN when last read issued;
//    DRAIN -> IDLE on handshake of the m_last_o beat (done_o=1 next cycle).
//    start_i with len_i==0: stay IDLE, busy_o stays 0, done_o pulses next cycle, no beats.
//    start_i while busy_o==1: ignored, no effect on current command.
//  - Issue rule (RUN): read issued in a cycle iff fill+pending<2, or fill+pending==2 and
//    a handshake occurs that cycle. Issue => pending<=1, addr<=addr+1, remaining<=remaining-1.
//    Non-issue cycles hold rom_addr_o stable.
//  - pending==1 => rom_data_i written into buffer at next edge, tagged last if it was the
//    final read. rom_data_i is ignored when pending==0 (ROM has no enable).
//  - Address arithmetic modulo 2**ADDR_WIDTH: base=0xFF,len=3 reads 0xFF,0x00,0x01.
//    len==2**ADDR_WIDTH reads every word once, starting at base.
//  - Latency: start accepted at edge T -> rom_addr_o=base during T+1 -> word buffered at
//    edge end of T+2 -> first m_valid_o=1 in cycle T+3. No bubbles while m_ready_i=1.
//  - Stream rules: m_data_o/m_last_o stable while m_valid_o & !m_ready_i; m_valid_o never
//    drops without a handshake; simultaneous buffer write and pop allowed at any fill.
//  - Buffer never overflows: fill+pending<=2 is an invariant (assert in RTL).
// STRUCTURE
//  - rom_streamer_pkg: state_t enum {IDLE, RUN, DRAIN}; BUF_DEPTH=2 localparam.
//  - Sub-module stream_fifo2: 2-entry registered FIFO (data+last), wr/rd, fill count,
//    simultaneous wr/rd; instantiated once. Top holds FSM, address and length counters.
// TESTING (bench uses a real ROM instance loaded with mem[i]=i^8'hA5)
//  1. base=0x10,len=4,m_ready_i=1 -> beats A5^10..A5^13 on T+3..T+6, last on 4th, done T+7.
//  2. base=0xFE,len=4 -> addresses FE,FF,00,01 -> data 5B,5A,A5,A4; last on 0x01 word.
//  3. len=8, m_ready_i toggles 1,0,0,1 random -> 8 in-order beats, data stable while
//     stalled, fill never >2, done_o once.
//  4. len=0 -> no m_valid_o, busy_o stays 0, done_o pulses 1 cycle after start.
//  5. start_i re-pulsed mid-command (base=0x80) -> ignored; original sequence intact.
//  6. rst_n_i low 1 cycle after 2 beats of len=6 -> all outputs to reset values next edge,
//     no done_o; new start base=0,len=2 then streams A5,A4 normally.

Source files
------------

// File: rtl/rom_streamer_pkg.sv
// Shared types and sizing for the ROM read-side streamer.
// The buffer depth is what lets the stream run at one word per cycle despite the ROM latency.
package rom_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/rom_streamer_if.sv
// Output word stream of the ROM streamer: valid/ready handshake with last-beat flag.
interface rom_streamer_if
  import rom_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_last_o;
  logic                  m_ready_i;

  modport master (output m_data_o, m_valid_o, m_last_o, input m_ready_i);
  modport slave  (input m_data_o, m_valid_o, m_last_o, output m_ready_i);
endinterface

// File: rtl/rom_streamer_stream_fifo2.sv
// Two-entry FIFO; entry e0 is always the head, so the output data, last and valid all come straight from flops.
// A write and a pop may happen in the same cycle at any fill level.
module stream_fifo2
  import rom_streamer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         wr_last,
  input  logic         rd_en,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic         head_vld,
  output logic [1:0]   fill
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } ent_t;

  ent_t          e0, e1, din;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pop;

  assign din = '{last: wr_last, data: wr_data};
  assign pop = rd_en && (cnt != '0);

  always_comb begin
    cnt_nxt = cnt + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      e0       <= '0;
      e1       <= '0;
      cnt      <= '0;
      head_vld <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      head_vld <= (cnt_nxt != '0);
      case ({wr_en, pop})
        2'b11: begin
          if (cnt == CW'(1)) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        2'b01: begin
          // Emptying pop keeps the data but drops last, so last never shows without a live word.
          if (cnt == CW'(BUF_DEPTH)) e0 <= e1;
          else                       e0.last <= 1'b0;
        end
        2'b10: begin
          if (cnt == '0) e0 <= din;
          else           e1 <= din;
        end
        default: ;
      endcase
    end
  end

  assign head_data = e0.data;
  assign head_last = e0.last;
  assign fill      = 2'(cnt);

endmodule

// File: rtl/rom_streamer.sv
// Walks ROM addresses base..base+len-1 and streams each word out with a last flag.
// The ROM answers one cycle after the address, so reads are only issued when the buffer has room for the reply.
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  rom_streamer_if.master        m
);
  localparam int LW = ADDR_WIDTH + 1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LW-1:0]           remaining;
  logic                    pending;
  logic                    pend_last;
  logic                    busy;
  logic                    done;

  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_last;
  logic                    head_vld;
  logic [1:0]              fill;
  logic [2:0]              occ;
  logic                    hs;
  logic                    issue;

  assign hs  = head_vld && m.m_ready_i;
  assign occ = {1'b0, fill} + {2'b0, pending};

  // A full buffer can still take a read when a handshake frees a slot this very cycle.
  assign issue = (state == RUN) &&
                 ((occ < 3'(BUF_DEPTH)) || ((occ == 3'(BUF_DEPTH)) && hs));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      pend_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= issue;
      if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - LW'(1);
        pend_last <= (remaining == LW'(1));
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state     <= RUN;
              busy      <= 1'b1;
              addr      <= base_i;
              remaining <= len_i;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (remaining == LW'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (hs && head_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en     (pending),
    .wr_data   (rom_data_i),
    .wr_last   (pend_last),
    .rd_en     (m.m_ready_i),
    .head_data (head_data),
    .head_last (head_last),
    .head_vld  (head_vld),
    .fill      (fill)
  );

  assign m.m_data_o  = head_data;
  assign m.m_valid_o = head_vld;
  assign m.m_last_o  = head_last;
  assign busy_o      = busy;
  assign done_o      = done;
  assign rom_addr_o  = addr;

  always_ff @(posedge clk_i) begin
    if (rst_n_i) assert (occ <= 3'(BUF_DEPTH));
  end

endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer against a synchronous ROM holding mem[i] = i ^ 8'hA5.
module tb_rom_streamer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base = '0;
  logic [8:0] len = '0;
  logic       busy, done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] rom_mem [256];
  int         nchecks = 0;
  int         nfail = 0;

  rom_streamer_if #(.DATA_WIDTH(8)) m_if ();

  rom_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .base_i     (base),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .m          (m_if)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [7:0] exp_word(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Leaves the caller just after the accepting edge T, inside cycle T+1.
  task automatic issue_start(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_if.m_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nchecks++;
    if ({m_if.m_valid_o, m_if.m_last_o, busy, done} !== 4'b0 || m_if.m_data_o !== 8'h00 || rom_addr !== 8'h00)
      begin nfail++; $display("FAIL reset: valid=%b last=%b busy=%b done=%b data=%h addr=%h, required all zero",
        m_if.m_valid_o, m_if.m_last_o, busy, done, m_if.m_data_o, rom_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Full-rate command with ready held high: beats on T+3..T+len+2, done one cycle later.
  task automatic test_stream(input string nm, input logic [7:0] b, input logic restart);
    logic ev, el, ed, eb;
    m_if.m_ready_i = 1'b1;
    issue_start(b, 9'd4);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ev = (k >= 3 && k <= 6); el = (k == 6); ed = (k == 7); eb = (k <= 6);
      if (k == 1) begin
        nchecks++;
        if (rom_addr !== b) begin nfail++;
          $display("FAIL %s first_addr: got %h, required %h", nm, rom_addr, b); end
      end
      nchecks++;
      if (m_if.m_valid_o !== ev || (ev && (m_if.m_last_o !== el || m_if.m_data_o !== exp_word(8'(b + k - 3))))
          || done !== ed || busy !== eb) begin
        nfail++;
        $display("FAIL %s cycle T+%0d: valid=%b last=%b data=%h done=%b busy=%b, required valid=%b last=%b data=%h done=%b busy=%b",
          nm, k, m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o, done, busy, ev, el, exp_word(8'(b + k - 3)), ed, eb);
      end
      if (restart && k == 1) begin start = 1'b1; base = 8'h80; len = 9'd3; end
      if (restart && k == 2) start = 1'b0;
    end
  endtask

  task automatic test_basic();     test_stream("basic", 8'h10, 1'b0); endtask
  task automatic test_wrap();      test_stream("wrap", 8'hFE, 1'b0); endtask
  task automatic test_restart_ignored(); test_stream("restart", 8'h10, 1'b1); endtask

  task automatic test_backpressure();
    logic [31:0] pat;
    logic [7:0]  got [$];
    int          dones;
    logic        pv, pr, pl;
    logic [7:0]  pd;
    pat = 32'b1011_0101_1000_1101_0011_1011_0101_1001;
    dones = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    issue_start(8'h40, 9'd8);
    m_if.m_ready_i = pat[0];
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (pv && !pr) begin
        nchecks++;
        if (m_if.m_valid_o !== 1'b1 || m_if.m_data_o !== pd || m_if.m_last_o !== pl) begin nfail++;
          $display("FAIL stall_hold cycle %0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
            k, m_if.m_valid_o, m_if.m_data_o, m_if.m_last_o, pd, pl); end
      end
      nchecks++;
      if (dut.fill > 2'd2) begin nfail++;
        $display("FAIL fill_bound cycle %0d: got %0d, required <=2", k, dut.fill); end
      if (m_if.m_valid_o && m_if.m_ready_i) begin
        nchecks++;
        if (m_if.m_last_o !== (got.size() == 7)) begin nfail++;
          $display("FAIL bp_last beat %0d: got %b, required %b", got.size(), m_if.m_last_o, got.size() == 7); end
        got.push_back(m_if.m_data_o);
      end
      if (done) dones++;
      pv = m_if.m_valid_o; pr = m_if.m_ready_i; pd = m_if.m_data_o; pl = m_if.m_last_o;
      @(posedge clk); #1;
      m_if.m_ready_i = pat[k % 32];
    end
    nchecks++;
    if (got.size() != 8) begin nfail++;
      $display("FAIL bp_count: got %0d beats, required 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      nchecks++;
      if (got[i] !== exp_word(8'(8'h40 + i))) begin nfail++;
        $display("FAIL bp_data beat %0d: got %h, required %h", i, got[i], exp_word(8'(8'h40 + i))); end
    end
    nchecks++;
    if (dones != 1 || busy !== 1'b0) begin nfail++;
      $display("FAIL bp_done: done pulses=%0d busy=%b, required 1 and 0", dones, busy); end
    m_if.m_ready_i = 1'b1;
  endtask

  task automatic test_len0();
    m_if.m_ready_i = 1'b1;
    issue_start(8'h33, 9'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      nchecks++;
      if (done !== (k == 1) || busy !== 1'b0 || m_if.m_valid_o !== 1'b0) begin nfail++;
        $display("FAIL len0 cycle T+%0d: done=%b busy=%b valid=%b, required done=%b busy=0 valid=0",
          k, done, busy, m_if.m_valid_o, k == 1); end
    end
  endtask

  task automatic test_midreset();
    logic ev, el, ed, eb;
    m_if.m_ready_i = 1'b1;
    issue_start(8'h30, 9'd6);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        nchecks++;
        if (m_if.m_valid_o !== 1'b1 || m_if.m_data_o !== exp_word(8'(8'h30 + k - 3))) begin nfail++;
          $display("FAIL mid_pre beat T+%0d: valid=%b data=%h, required 1 %h",
            k, m_if.m_valid_o, m_if.m_data_o, exp_word(8'(8'h30 + k - 3))); end
      end
    end
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nchecks++;
      if ({m_if.m_valid_o, m_if.m_last_o, busy, done} !== 4'b0 ||
          (k == 0 && (m_if.m_data_o !== 8'h00 || rom_addr !== 8'h00))) begin nfail++;
        $display("FAIL mid_reset cycle %0d: valid=%b last=%b busy=%b done=%b data=%h addr=%h, required zeros",
          k, m_if.m_valid_o, m_if.m_last_o, busy, done, m_if.m_data_o, rom_addr); end
    end
    issue_start(8'h00, 9'd2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ev = (k == 3 || k == 4); el = (k == 4); ed = (k == 5); eb = (k <= 4);
      nchecks++;
      if (m_if.m_valid_o !== ev || (ev && (m_if.m_last_o !== el || m_if.m_data_o !== exp_word(8'(k - 3))))
          || done !== ed || busy !== eb) begin nfail++;
        $display("FAIL post_reset cycle T+%0d: valid=%b last=%b data=%h done=%b busy=%b, required valid=%b last=%b data=%h done=%b busy=%b",
          k, m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o, done, busy, ev, el, exp_word(8'(k - 3)), ed, eb);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_restart_ignored();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
